// File: rtl/core_types_pkg.sv
// Shared core types: the ALU operation code, the execute-unit state enum and a shift classifier.
package core_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        EXEC_IDLE  = 2'd0,
        EXEC_SHIFT = 2'd1,
        EXEC_DONE  = 2'd2
    } alu_exec_state_t;

    function automatic logic alu_is_shift(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift of the iterative shifter's working register, selected by the shift op.
module alu_shift_step
    import core_types_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_t           op,
    input  logic [XLEN-1:0]   data,
    output logic [XLEN-1:0]   shifted
);

    always_comb begin
        shifted = data;
        case (op)
            ALU_SLL: shifted = {data[XLEN-2:0], 1'b0};
            ALU_SRL: shifted = {1'b0, data[XLEN-1:1]};
            ALU_SRA: shifted = {data[XLEN-1], data[XLEN-1:1]};
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready in and out; shifts are iterative (1 bit/cycle) unless
// ALU_BARREL_SHIFT_EN is defined, in which case every op completes in a single cycle.
module alu_exec_unit
    import core_types_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_t           alu_op,
    input  logic [XLEN-1:0]   operand_a,
    input  logic [XLEN-1:0]   operand_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              busy
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    alu_exec_state_t    state_q;
    alu_exec_state_t    state_d;
    logic               accept;
    logic               start_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;

    assign shamt  = operand_b[SHAMT_W-1:0];
    assign accept = in_valid && in_ready;

`ifdef ALU_BARREL_SHIFT_EN
    assign start_shift = 1'b0;
`else
    // A zero shift amount is just a pass-through and completes like any other op.
    assign start_shift = alu_is_shift(alu_op) && (shamt != '0);
`endif

    // Single-cycle result; unknown op codes fall back to ADD.
    always_comb begin
        alu_res = operand_a + operand_b;
        case (alu_op)
            ALU_ADD:  alu_res = operand_a + operand_b;
            ALU_SUB:  alu_res = operand_a - operand_b;
            ALU_SLT:  alu_res = XLEN'($signed(operand_a) < $signed(operand_b));
            ALU_SLTU: alu_res = XLEN'(operand_a < operand_b);
            ALU_XOR:  alu_res = operand_a ^ operand_b;
            ALU_OR:   alu_res = operand_a | operand_b;
            ALU_AND:  alu_res = operand_a & operand_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  alu_res = operand_a << shamt;
            ALU_SRL:  alu_res = operand_a >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(operand_a) >>> shamt);
`else
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_res = operand_a;
`endif
            default:  alu_res = operand_a + operand_b;
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    logic [XLEN-1:0]    work_q;
    logic [XLEN-1:0]    work_step;
    logic [SHAMT_W-1:0] count_q;
    alu_op_t            shift_op_q;
    logic               shift_last;

    alu_shift_step #(
        .XLEN    (XLEN)
    ) u_shift_step (
        .op      (shift_op_q),
        .data    (work_q),
        .shifted (work_step)
    );

    assign shift_last = (count_q == SHAMT_W'(1));

    // Iterative shifter working register and remaining-bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q     <= '0;
            count_q    <= '0;
            shift_op_q <= ALU_ADD;
        end else if (accept && start_shift) begin
            work_q     <= operand_a;
            count_q    <= shamt;
            shift_op_q <= alu_op;
        end else if (state_q == EXEC_SHIFT) begin
            work_q     <= work_step;
            count_q    <= count_q - SHAMT_W'(1);
        end
    end
`endif

    // Result register: loaded on single-cycle accepts or on the final shift step.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (accept && !start_shift) begin
            result <= alu_res;
`ifndef ALU_BARREL_SHIFT_EN
        end else if ((state_q == EXEC_SHIFT) && shift_last) begin
            result <= work_step;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EXEC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EXEC_IDLE: begin
                if (accept) begin
                    state_d = start_shift ? EXEC_SHIFT : EXEC_DONE;
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            EXEC_SHIFT: begin
                if (shift_last) begin
                    state_d = EXEC_DONE;
                end
            end
`endif
            EXEC_DONE: begin
                // A simultaneous accept hands straight over to the next op without a bubble.
                if (accept) begin
                    state_d = start_shift ? EXEC_SHIFT : EXEC_DONE;
                end else if (out_ready) begin
                    state_d = EXEC_IDLE;
                end
            end
            default: state_d = EXEC_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            EXEC_IDLE: in_ready = !rst;
`ifndef ALU_BARREL_SHIFT_EN
            EXEC_SHIFT: busy = 1'b1;
`endif
            EXEC_DONE: begin
                out_valid = 1'b1;
                in_ready  = !rst && out_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level latency/result model.
module tb_alu_exec_unit;
    import core_types_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
    localparam int ITER = 0;
`else
    localparam int ITER = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    alu_op_t     alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: at most one op in flight, visible from edge rdy onward; last = previously delivered result.
    int          cyc  = 0;
    bit          mok  = 0;
    bit          pend = 0;
    int          rdy  = 0;
    logic [31:0] pres = '0;
    logic [31:0] last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return 32'($signed(a) >>> sh);
            default:  return a + b;
        endcase
    endfunction

    function automatic int ref_lat(input alu_op_t op, input logic [31:0] b);
        if (ITER == 1 && (op == ALU_SLL || op == ALU_SRL || op == ALU_SRA))
            return int'(b[4:0]);
        return 0;
    endfunction

    always @(posedge clk) begin : model
        bit done_now;
        bit inr;
        if (rst) begin
            pend = 0;
            last = '0;
            mok  = 1;
        end else if (mok) begin
            done_now = pend && (cyc >= rdy);
            inr      = !pend || (done_now && out_ready);
            if (done_now && out_ready) begin
                pend = 0;
                last = pres;
            end
            if (in_valid && inr) begin
                pend = 1;
                pres = ref_alu(alu_op, operand_a, operand_b);
                rdy  = cyc + 1 + ref_lat(alu_op, operand_b);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (mok) begin
            chk("out_valid", 32'(out_valid), 32'(pend && (cyc >= rdy)));
            chk("busy",      32'(busy),      32'(pend && (cyc < rdy)));
            chk("in_ready",  32'(in_ready),  32'(!rst && (!pend || ((cyc >= rdy) && out_ready))));
            chk("result",    result,         (pend && (cyc >= rdy)) ? pres : last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE with out_ready high and check literal result, latency and busy time.
    task automatic run_op(input string name, input alu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n0;
        int busy_cnt;
        bit seen;
        busy_cnt  = 0;
        seen      = 0;
        in_valid  = 1'b1;
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n0 = cyc;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            tick();
        end
        chk({name, " seen"},        32'(seen),       32'd1);
        chk({name, " result"},      result,          exp_res);
        chk({name, " latency"},     32'(cyc - n0),   32'(exp_lat));
        chk({name, " busy cycles"}, 32'(busy_cnt),   32'(exp_lat));
        tick();
        chk({name, " drained"},     32'(out_valid),  32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = ALU_ADD;
        operand_a = '0;
        operand_b = '0;
        tick();
        tick();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result",    result,         32'h0);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        run_op("add wrap", ALU_ADD,  32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 0);
        run_op("sub wrap", ALU_SUB,  32'h0,         32'h1,  32'hFFFF_FFFF, 0);
        run_op("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'h1,  32'h1,         0);
        run_op("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'h1,  32'h0,         0);
        run_op("sra 4",    ALU_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000, 4 * ITER);
        run_op("srl 0",    ALU_SRL,  32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 0);
        run_op("bad op",   alu_op_t'(4'd12), 32'd3, 32'd4, 32'd7,          0);

        // Backpressure, then handoff to a new op in the same cycle the result is taken.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = ALU_ADD;
        operand_a = 32'd5;
        operand_b = 32'd6;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall result",    result,         32'd11);
            chk("stall in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = ALU_XOR;
        operand_a = 32'h0000_F0F0;
        operand_b = 32'h0000_FFFF;
        #1;
        chk("handoff in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("no bubble out_valid", 32'(out_valid), 32'd1);
        chk("no bubble result",    result,         32'h0000_0F0F);
        tick();
        chk("handoff drained", 32'(out_valid), 32'd0);

        // Reset during the tenth shift cycle of a long SLL.
        in_valid  = 1'b1;
        alu_op    = ALU_SLL;
        operand_a = 32'h1;
        operand_b = 32'd31;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("mid-shift busy", 32'(busy), 32'(ITER));
        rst = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort result",    result,         32'h0);
        chk("abort busy",      32'(busy),      32'd0);
        rst = 1'b0;
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        run_op("or after abort", ALU_OR, 32'h1, 32'h2, 32'h3, 0);

        // Randomized traffic; the per-cycle model check does the work here.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            alu_op    = alu_op_t'(4'($urandom_range(0, 11)));
            operand_a = pick();
            operand_b = pick();
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the alu_op_t code produced by the ALU decode logic.
- Accepts one operation with two operands over a valid/ready handshake and returns a registered result over a second valid/ready handshake.
- Shifts run iteratively, one bit per cycle; all other ops complete in one cycle.
- Sits between decode/operand-read and writeback in the core.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.
- SHAMT_W, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation this cycle.
- alu_op  input  alu_op_t  operation code (ALU_ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND).
- operand_a  input  XLEN  first operand.
- operand_b  input  XLEN  second operand; low SHAMT_W bits are the shift amount.
- out_valid  output  1  result available.
- out_ready  input  1  downstream takes the result.
- result  output  XLEN  registered result.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, out_valid=0, result=0, busy=0, shift counter=0. in_ready=0 combinationally while rst is high.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, busy=1.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept condition: in_valid && in_ready. alu_op and operands are sampled only on an accept; they are ignored at all other times.
- Accept of a non-shift op, or a shift with shamt=0 (accept in cycle T): result registered; DONE in cycle T+1.
- Accept of a shift with shamt≠0: working reg=operand_a, count=shamt; SHIFT in T+1.
- SHIFT: each cycle shifts the working reg 1 bit (SLL left zero-fill, SRL right zero-fill, SRA right sign-fill) and decrements count. On the cycle count reaches 0, result=working reg and state→DONE. out_valid rises in cycle T+1+shamt.
- DONE: result and out_valid are held stable while out_ready=0.
  - out_ready=1, no accept: →IDLE, out_valid=0 next cycle.
  - out_ready=1 with a simultaneous accept: the new op is taken in the same cycle; the next state follows the accept rules above (no bubble).
- Arithmetic:
  - ADD/SUB wrap mod 2^XLEN.
  - SLT signed compare, SLTU unsigned compare; result is 1 or 0, zero-extended.
  - XOR/OR/AND bitwise.
  - Shift amount = operand_b[SHAMT_W-1:0]; upper bits ignored.
- Reset mid-SHIFT or mid-DONE: the in-flight op is discarded with no output; IDLE next cycle.
- Out-of-range enum value: treated as ALU_ADD.

Optional Feature:
- Macro ALU_BARREL_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter. SHIFT state is not compiled in, busy is tied 0, and every op reaches DONE in T+1.
- Undefined: iterative shifter as above.
- Results are identical in both builds; only latency differs.

Decomposition:
- alu_op_t is taken from core_types_pkg; no local redefinition.
- The exec-state enum (IDLE/SHIFT/DONE) is added to core_types_pkg as alu_exec_state_t.
- One sub-module, alu_shift_step: combinational 1-bit shift of the working reg by op. Replaced by a full barrel shift under ALU_BARREL_SHIFT_EN.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001, accepted at T, out_ready=1 → result 0x80000000, out_valid in T+1 only. SUB 0x0−0x1 → 0xFFFFFFFF.
- SLT a=0xFFFFFFFF, b=0x1 → 1. SLTU with the same operands → 0.
- SRA 0x80000000 by b=0x24 (shamt 4) → 0xF8000000; busy high T+1..T+4, out_valid at T+5. With ALU_BARREL_SHIFT_EN: out_valid at T+1, busy never high.
- Backpressure: ADD result with out_ready=0 for 3 cycles → result and out_valid stable, in_ready=0. out_ready=1 together with a new XOR 0xF0F0^0xFFFF → next result 0x0F0F one cycle later, no bubble.
- SLL 0x1 by shamt 31, rst asserted in the 10th SHIFT cycle → next cycle state IDLE, out_valid=0, result=0. After rst deasserts, in_ready=1 and a fresh OR 0x1|0x2 returns 0x3.
- Shift with shamt=0 (SRL 0xDEADBEEF, b=0x20) → result 0xDEADBEEF at T+1, busy never high.
